// File: rtl/forward_net_if.sv
// Bundle of pipeline-side signals exchanged with the forwarding network.
// The master side drives the producer-stage, read-port and control inputs;
// the slave side (forward_net) returns the select, data, stall and count.
interface forward_net_if #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_RPORTS = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STALL_W    = 4
);
    logic                         flush;
    logic [STALL_W-1:0]           stall;
    logic [NUM_RPORTS*ADDR_W-1:0] rf_raddr;
    logic [NUM_STAGES-1:0]        stg_we;
    logic [NUM_STAGES*ADDR_W-1:0] stg_waddr;
    logic [NUM_STAGES*DATA_W-1:0] stg_wdata;
    logic [NUM_STAGES-1:0]        stg_is_load;
    logic                         stallreq_for_load;
    logic [NUM_RPORTS-1:0]        fwd_sel_r;
    logic [NUM_RPORTS*DATA_W-1:0] fwd_data_r;
    logic [31:0]                  load_stall_cnt;

    modport master (
        output flush, stall, rf_raddr, stg_we, stg_waddr, stg_wdata, stg_is_load,
        input  stallreq_for_load, fwd_sel_r, fwd_data_r, load_stall_cnt
    );

    modport slave (
        input  flush, stall, rf_raddr, stg_we, stg_waddr, stg_wdata, stg_is_load,
        output stallreq_for_load, fwd_sel_r, fwd_data_r, load_stall_cnt
    );
endinterface

// File: rtl/forward_net.sv
// Operand forwarding network: picks the youngest producer stage writing each
// read port's register, flags load-use hazards combinationally, registers the
// forward select/data for the next stage and counts load-use stall cycles.
module forward_net #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_RPORTS = 2,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int ZERO_REG   = 1,
    parameter int HOLD_BIT   = 2,
    parameter int STALL_W    = 4
) (
    input  logic          clk,
    input  logic          rst,
    forward_net_if.slave  bus
);

    logic [NUM_RPORTS-1:0]        sel_c;
    logic [NUM_RPORTS*DATA_W-1:0] data_c;
    logic [NUM_RPORTS-1:0]        load_hit_c;
    logic [NUM_RPORTS-1:0]        sel_q;
    logic [NUM_RPORTS*DATA_W-1:0] data_q;
    logic [31:0]                  cnt_q;
    logic                         hold;
    logic                         stall_unused;

    assign hold = bus.stall[HOLD_BIT];
    // Only the decode-hold bit matters here; the other bits steer other stages.
    assign stall_unused = ^bus.stall;

    // Per-port match search; stages are scanned oldest to youngest so the
    // lowest-index match is written last and wins, load or not.
    always_comb begin
        sel_c      = '0;
        data_c     = '0;
        load_hit_c = '0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                if (bus.stg_we[s] &&
                    (bus.stg_waddr[s*ADDR_W +: ADDR_W] == bus.rf_raddr[p*ADDR_W +: ADDR_W]) &&
                    !((ZERO_REG != 0) && (bus.rf_raddr[p*ADDR_W +: ADDR_W] == '0))) begin
                    sel_c[p]                   = 1'b1;
                    data_c[p*DATA_W +: DATA_W] = bus.stg_wdata[s*DATA_W +: DATA_W];
                    load_hit_c[p]              = bus.stg_is_load[s];
                end
            end
        end
    end

    assign bus.stallreq_for_load = |load_hit_c;

    // Forward select/data register: reset, then flush, then hold, else capture.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            sel_q  <= '0;
            data_q <= '0;
        end else if (!hold) begin
            sel_q  <= sel_c;
            data_q <= data_c;
        end
    end

    // Saturating load-use stall cycle counter; ignores flush and hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (bus.stallreq_for_load && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign bus.fwd_sel_r      = sel_q;
    assign bus.fwd_data_r     = data_q;
    assign bus.load_stall_cnt = cnt_q;

endmodule
